// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit for the E stage, owner of the HI/LO registers.
//
// The unit executes mult/multu/div/divu/madd/maddu/msub/msubu and mthi/mtlo.
// Multiply and divide operands are captured when the request is accepted.
// The unit then stays busy for a fixed number of cycles and commits the
// result to HI/LO on the edge that ends its last busy cycle. mthi/mtlo write
// directly on the accepting edge and never raise busy.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu/madd/maddu/msub/msubu (>=1)
//   DIV_CYCLES   busy cycles for div/divu (>=1)
//
// Ports:
//   clk    in   1   clock, rising-edge active
//   reset  in   1   asynchronous, active-low; clears all state
//   start  in   1   one-cycle request from the E-stage valid instruction
//   op     in   4   0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu,
//                   6 msub, 7 msubu, 8 mthi, 9 mtlo, 10-15 no-op
//   a      in  32   rs operand
//   b      in  32   rt operand
//   busy   out  1   operation in flight (registered)
//   hi     out 32   HI register
//   lo     out 32   LO register
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;

  // Result datapath, evaluated from the captured operands.
  logic        signed_mul;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic [63:0] hilo_cur;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] divisor;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_we;

  // Multiplier: extending both operands to 64 bits (sign or zero) makes a
  // single 64-bit wrapping product correct for both signed and unsigned forms.
  always_comb begin
    signed_mul = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    ext_a      = signed_mul ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    ext_b      = signed_mul ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    product    = ext_a * ext_b;
    hilo_cur   = {hi_q, lo_q};
  end

  // Divider: works on magnitudes so that the most-negative dividend divided
  // by -1 wraps to 0x80000000 instead of overflowing. A zero divisor is
  // replaced by one only to keep the arithmetic defined; the result is
  // discarded in that case.
  always_comb begin
    a_neg    = (op_q == OP_DIV) && a_q[31];
    b_neg    = (op_q == OP_DIV) && b_q[31];
    abs_a    = a_neg ? (32'd0 - a_q) : a_q;
    abs_b    = b_neg ? (32'd0 - b_q) : b_q;
    divisor  = (abs_b == 32'd0) ? 32'd1 : abs_b;
    quot_mag = abs_a / divisor;
    rem_mag  = abs_a % divisor;
    div_quot = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
    div_rem  = a_neg ? (32'd0 - rem_mag) : rem_mag;
  end

  // Select what gets committed to HI/LO at the end of the operation.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b0;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        {res_hi, res_lo} = product;
        res_we           = 1'b1;
      end
      OP_MADD, OP_MADDU: begin
        {res_hi, res_lo} = hilo_cur + product;
        res_we           = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        {res_hi, res_lo} = hilo_cur - product;
        res_we           = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_hi = div_rem;
        res_lo = div_quot;
        res_we = (b_q != 32'd0);
      end
      default: begin
        res_we = 1'b0;
      end
    endcase
  end

  // Control: accept requests only in IDLE with busy low, count down in RUN
  // and commit on the last busy cycle. Requests seen while busy, including
  // the final busy cycle, fall through untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op <= OP_MSUBU) begin
            op_d    = op;
            a_d     = a;
            b_d     = b;
            cnt_d   = ((op == OP_DIV) || (op == OP_DIVU)) ? CNT_DIV : CNT_MULT;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_RUN: begin
        if (cnt_q <= CNT_LAST) begin
          if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; an active-low reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: self-checking bench for mdu_hilo.
// Runs the directed scenarios first, followed by random operations. Every
// result is compared against a HI/LO model built on 64-bit integer arithmetic.
module tb_mdu_hilo;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_hilo #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: applies one accepted operation to the HI/LO pair.
  task automatic modelApply(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy;
    logic [63:0]     acc, prod;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    ux   = longint'({32'b0, x});
    uy   = longint'({32'b0, y});
    acc  = {m_hi, m_lo};
    prod = ((o == 4'd0) || (o == 4'd4) || (o == 4'd6)) ? 64'(sx * sy) : 64'(ux * uy);
    case (o)
      4'd0, 4'd1: {m_hi, m_lo} = prod;
      4'd4, 4'd5: {m_hi, m_lo} = acc + prod;
      4'd6, 4'd7: {m_hi, m_lo} = acc - prod;
      4'd2: begin
        if (y != 32'd0) begin
          sq   = sx / sy;
          sr   = sx % sy;
          m_lo = sq[31:0];
          m_hi = sr[31:0];
        end
      end
      4'd3: begin
        if (y != 32'd0) begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
      4'd8: m_hi = x;
      4'd9: m_lo = x;
      default: ;
    endcase
  endtask

  // Number of busy cycles an operation should produce.
  function automatic int expectedBusy(input logic [3:0] o);
    if ((o == 4'd2) || (o == 4'd3)) return DIV_CYCLES;
    if (o <= 4'd7) return MULT_CYCLES;
    return 0;
  endfunction

  // Counts busy cycles at negedges. The wait is bounded and returns the count.
  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Issue one request, wait for completion and check busy length and HI/LO.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    waitIdle(n);
    modelApply(o, x, y);
    checkOutput($sformatf("busy_len op%0d", o), 64'(n), 64'(expectedBusy(o)));
    checkOutput($sformatf("hi op%0d", o), {32'b0, hi}, {32'b0, m_hi});
    checkOutput($sformatf("lo op%0d", o), {32'b0, lo}, {32'b0, m_lo});
  endtask

  initial begin
    int          n;
    logic [3:0]  ro;
    logic [31:0] rx, ry;

    reset = 1'b0;
    start = 1'b0;
    op    = 4'd0;
    a     = 32'd0;
    b     = 32'd0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;

    #12;
    checkOutput("reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("reset_hi", {32'b0, hi}, 64'd0);
    checkOutput("reset_lo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed scenarios with hand-computed results.
    applyStimulus(4'd0, 32'hFFFF_FFFD, 32'd5);
    checkOutput("tp_mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    checkOutput("tp_mult_lo", {32'b0, lo}, 64'hFFFF_FFF1);

    applyStimulus(4'd1, 32'hFFFF_FFFF, 32'd2);
    checkOutput("tp_multu_hi", {32'b0, hi}, 64'h1);
    checkOutput("tp_multu_lo", {32'b0, lo}, 64'hFFFF_FFFE);

    applyStimulus(4'd2, 32'hFFFF_FFF9, 32'd2);
    checkOutput("tp_div_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    checkOutput("tp_div_lo", {32'b0, lo}, 64'hFFFF_FFFD);

    applyStimulus(4'd8, 32'd0, 32'd0);
    applyStimulus(4'd9, 32'hFFFF_FFFF, 32'd0);
    applyStimulus(4'd5, 32'd1, 32'd1);
    checkOutput("tp_maddu_hi", {32'b0, hi}, 64'h1);
    checkOutput("tp_maddu_lo", {32'b0, lo}, 64'h0);
    applyStimulus(4'd6, 32'd1, 32'd1);
    checkOutput("tp_msub_hi", {32'b0, hi}, 64'h0);
    checkOutput("tp_msub_lo", {32'b0, lo}, 64'hFFFF_FFFF);

    applyStimulus(4'd8, 32'h12, 32'd0);
    applyStimulus(4'd9, 32'h34, 32'd0);
    applyStimulus(4'd3, 32'd7, 32'd0);
    checkOutput("tp_divu0_hi", {32'b0, hi}, 64'h12);
    checkOutput("tp_divu0_lo", {32'b0, lo}, 64'h34);

    applyStimulus(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("tp_divovf_hi", {32'b0, hi}, 64'h0);
    checkOutput("tp_divovf_lo", {32'b0, lo}, 64'h8000_0000);

    applyStimulus(4'd12, 32'hDEAD_BEEF, 32'd3);

    // mthi pulsed mid-operation must be dropped.
    @(negedge clk);
    start = 1'b1;
    op    = 4'd0;
    a     = 32'h1234;
    b     = 32'h10;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 2) begin
        start = 1'b1;
        op    = 4'd8;
        a     = 32'hAAAA;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    modelApply(4'd0, 32'h1234, 32'h10);
    checkOutput("midbusy_len", 64'(n), 64'(MULT_CYCLES));
    checkOutput("midbusy_hi", {32'b0, hi}, {32'b0, m_hi});
    checkOutput("midbusy_lo", {32'b0, lo}, {32'b0, m_lo});

    // mtlo presented in the last busy cycle must also be dropped.
    @(negedge clk);
    start = 1'b1;
    op    = 4'd1;
    a     = 32'h7;
    b     = 32'h9;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == MULT_CYCLES) begin
        start = 1'b1;
        op    = 4'd9;
        a     = 32'h5555;
      end
      @(negedge clk);
    end
    start = 1'b0;
    modelApply(4'd1, 32'h7, 32'h9);
    checkOutput("lastbusy_len", 64'(n), 64'(MULT_CYCLES));
    checkOutput("lastbusy_lo", {32'b0, lo}, 64'd63);
    @(negedge clk);
    checkOutput("lastbusy_lo_after", {32'b0, lo}, 64'd63);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1;
    op    = 4'd2;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (busy && n < 4) begin
      n++;
      @(negedge clk);
    end
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_busy", {63'b0, busy}, 64'd0);
    checkOutput("async_hi", {32'b0, hi}, 64'd0);
    checkOutput("async_lo", {32'b0, lo}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'd0, 32'd2, 32'd3);
    checkOutput("postrst_hi", {32'b0, hi}, 64'd0);
    checkOutput("postrst_lo", {32'b0, lo}, 64'd6);

    // Random operations against the model.
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = $urandom;
      if ($urandom_range(0, 3) == 0) rx = 32'($urandom_range(0, 9));
      ry = $urandom;
      if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) ry = 32'hFFFF_FFFF;
      applyStimulus(ro, rx, ry);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
